sort4_seq_ctrl: RTL and testbench

- Sequencing controller that sorts a job of 4 unsigned W-bit values into ascending order.
- Reuses one shared magnitude comparator (one sosanhC2-style instance: inputs A, B; outputs X = A>B, Y = A==B, Z = A<B) through a bubble-sort FSM; one comparison per clock.
- Data enters and leaves as serial valid/ready beats.
- Sits between an input producer and a consumer in the comparator datapath.

---
 rtl/sort4_seq_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_sort4_seq_ctrl.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/sort4_seq_ctrl.sv
// sort4_seq_ctrl: sorts a four-element job of unsigned W-bit values into
// ascending order. Elements are loaded as serial valid/ready beats, sorted
// in place by a bubble-sort FSM, and drained smallest first.
//
// The FSM time-shares one magnitude comparator (sosanhC2) and makes one
// comparison per clock.
//
// Optional feature, selected by the macro SORT_EARLY_EXIT_EN:
//   - Defined: sorting stops at the end of the first pass that made no swap.
//   - Undefined (default): sorting always runs three full passes, which
//     gives a fixed latency.

// Shared magnitude comparator: X = A>B, Y = A==B, Z = A<B
module sosanhC2 #(
    parameter int unsigned W = 4
) (
    input  logic [W-1:0] A,
    input  logic [W-1:0] B,
    output logic         X,
    output logic         Y,
    output logic         Z
);

    // Unsigned relational decode of the two operands
    always_comb begin
        X = (A > B);
        Y = (A == B);
        Z = (A < B);
    end

endmodule

module sort4_seq_ctrl #(
    parameter int unsigned W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    input  logic [W-1:0] in_data,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_data,
    input  logic         out_ready,
    output logic         busy,
    output logic [3:0]   cmp_cnt,
    output logic [2:0]   swap_cnt
);

    // SETTLE separates the last compare/swap from the first output beat, so
    // out_valid only rises once the sorted buffer has been stable for a cycle.
    typedef enum logic [1:0] {
        LOAD   = 2'd0,
        SORT   = 2'd1,
        SETTLE = 2'd2,
        OUT    = 2'd3
    } state_t;

    state_t       state;
    logic [W-1:0] elem [4];
    logic [1:0]   ld_ptr;
    logic [1:0]   out_ptr;
    logic [1:0]   pass;
    logic [1:0]   idx;
    logic [1:0]   idx_p1;

`ifdef SORT_EARLY_EXIT_EN
    // Records whether any swap has happened so far in the current pass
    logic         swapped;
`endif

    logic [W-1:0] cmp_a;
    logic [W-1:0] cmp_b;
    logic         cmp_gt;
    logic         cmp_eq;
    logic         cmp_lt;
    logic         do_swap;
    logic         last_cmp;

    // Select the adjacent pair currently being compared
    always_comb begin
        idx_p1 = idx + 2'd1;
        cmp_a  = elem[idx];
        cmp_b  = elem[idx_p1];
    end

    sosanhC2 #(
        .W (W)
    ) u_cmp (
        .A (cmp_a),
        .B (cmp_b),
        .X (cmp_gt),
        .Y (cmp_eq),
        .Z (cmp_lt)
    );

    // Swap only on a strict greater-than; equal elements keep their order
    always_comb begin
        do_swap = cmp_gt & ~(cmp_eq | cmp_lt);
`ifdef SORT_EARLY_EXIT_EN
        last_cmp = (idx == 2'd2) && ((pass == 2'd2) || (!swapped && !do_swap));
`else
        last_cmp = (idx == 2'd2) && (pass == 2'd2);
`endif
    end

    // Handshake and status outputs decoded from the registered state
    always_comb begin
        in_ready  = (state == LOAD);
        out_valid = (state == OUT);
        busy      = (state != LOAD);
        out_data  = elem[out_ptr];
    end

    // Control FSM: load beats, bubble-sort passes, drain beats
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= LOAD;
            ld_ptr   <= '0;
            out_ptr  <= '0;
            pass     <= '0;
            idx      <= '0;
            cmp_cnt  <= '0;
            swap_cnt <= '0;
`ifdef SORT_EARLY_EXIT_EN
            swapped  <= 1'b0;
`endif
            for (int unsigned i = 0; i < 4; i++) begin
                elem[i] <= '0;
            end
        end else begin
            case (state)
                LOAD: begin
                    if (in_valid) begin
                        elem[ld_ptr] <= in_data;
                        ld_ptr       <= ld_ptr + 2'd1;
                        if (ld_ptr == 2'd3) begin
                            state    <= SORT;
                            cmp_cnt  <= '0;
                            swap_cnt <= '0;
                            pass     <= '0;
                            idx      <= '0;
`ifdef SORT_EARLY_EXIT_EN
                            swapped  <= 1'b0;
`endif
                        end
                    end
                end

                SORT: begin
                    cmp_cnt <= cmp_cnt + 4'd1;
                    if (do_swap) begin
                        elem[idx]    <= cmp_b;
                        elem[idx_p1] <= cmp_a;
                        swap_cnt     <= swap_cnt + 3'd1;
                    end
                    if (idx == 2'd2) begin
                        idx  <= '0;
                        pass <= pass + 2'd1;
`ifdef SORT_EARLY_EXIT_EN
                        swapped <= 1'b0;
`endif
                    end else begin
                        idx <= idx_p1;
`ifdef SORT_EARLY_EXIT_EN
                        if (do_swap) begin
                            swapped <= 1'b1;
                        end
`endif
                    end
                    if (last_cmp) begin
                        state <= SETTLE;
                    end
                end

                SETTLE: begin
                    state <= OUT;
                end

                OUT: begin
                    if (out_ready) begin
                        out_ptr <= out_ptr + 2'd1;
                        if (out_ptr == 2'd3) begin
                            state  <= LOAD;
                            ld_ptr <= '0;
                        end
                    end
                end

                default: begin
                    state <= LOAD;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sort4_seq_ctrl.sv
// Self-checking bench for sort4_seq_ctrl (W=4). Expected sorted data comes
// from a queue model filled when each job is loaded and drained as the DUT
// emits beats. Honours SORT_EARLY_EXIT_EN for latency/count expectations.
module tb_sort4_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [3:0] in_data;
    logic       in_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_ready;
    logic       busy;
    logic [3:0] cmp_cnt;
    logic [2:0] swap_cnt;

    int errors;
    int checks;
    logic [3:0] sb [$];

`ifdef SORT_EARLY_EXIT_EN
    localparam int SORTED_CMP = 3;
    localparam int SORTED_LAT = 4;
`else
    localparam int SORTED_CMP = 9;
    localparam int SORTED_LAT = 10;
`endif

    sort4_seq_ctrl #(.W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .busy      (busy),
        .cmp_cnt   (cmp_cnt),
        .swap_cnt  (swap_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Drive four beats; the sorted result goes to the scoreboard. Returns at
    // the falling edge just after the 4th beat was accepted.
    task automatic load_job(input logic [3:0] v0, input logic [3:0] v1,
                            input logic [3:0] v2, input logic [3:0] v3,
                            input bit junk);
        logic [3:0] vals [$];
        vals = {v0, v1, v2, v3};
        foreach (vals[i]) begin
            @(negedge clk);
            check("in_ready_load", in_ready, 1);
            in_valid = 1'b1;
            in_data  = vals[i];
        end
        vals.sort();
        foreach (vals[i]) sb.push_back(vals[i]);
        @(negedge clk);
        in_valid = junk;
        in_data  = 4'hF;
        check("busy_sort", busy, 1);
        check("in_ready_sort", in_ready, 0);
    endtask

    // Count falling edges until out_valid rises (bounded)
    task automatic wait_out(input int lat_exp);
        int k;
        k = 0;
        while (!out_valid && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("out_latency", k, lat_exp);
    endtask

    // Optional backpressure, then four transfers and return to LOAD
    task automatic unload(input int cmp_exp, input int swap_exp, input int bp);
        logic [3:0] exp;
        for (int b = 0; b < bp; b++) begin
            check("bp_valid", out_valid, 1);
            check("bp_data", out_data, (sb.size() > 0) ? sb[0] : 4'h0);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        for (int i = 0; i < 4; i++) begin
            check("out_valid", out_valid, 1);
            if (sb.size() == 0) begin
                check("sb_empty", 1, 0);
                exp = 4'h0;
            end else begin
                exp = sb.pop_front();
            end
            check("out_data", out_data, exp);
            out_ready = 1'b1;
            @(negedge clk);
        end
        out_ready = 1'b0;
        in_valid  = 1'b0;
        check("done_in_ready", in_ready, 1);
        check("done_out_valid", out_valid, 0);
        check("done_busy", busy, 0);
        check("cmp_cnt", cmp_cnt, cmp_exp);
        check("swap_cnt", swap_cnt, swap_exp);
    endtask

    initial begin
        int k;
        errors    = 0;
        checks    = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_busy", busy, 0);
        check("rst_cmp_cnt", cmp_cnt, 0);
        check("rst_swap_cnt", swap_cnt, 0);

        // Mixed values with a duplicate
        load_job(4'd9, 4'd2, 4'd7, 4'd2, 1'b0);
        wait_out(10);
        unload(9, 4, 0);

        // Already sorted
        load_job(4'd1, 4'd3, 4'd5, 4'd15, 1'b0);
        wait_out(SORTED_LAT);
        unload(SORTED_CMP, 0, 0);

        // Reverse order, with 5 cycles of backpressure
        load_job(4'd15, 4'd10, 4'd5, 4'd0, 1'b0);
        wait_out(10);
        unload(9, 6, 5);

        // Reset in the middle of sorting
        load_job(4'd9, 4'd2, 4'd7, 4'd2, 1'b0);
        k = 0;
        while (cmp_cnt != 4'd4 && k < 40) begin
            @(negedge clk);
            k++;
        end
        check("rst_wait_cmp4", cmp_cnt, 4);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        check("mid_rst_in_ready", in_ready, 1);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_out_valid", out_valid, 0);
        check("mid_rst_cmp_cnt", cmp_cnt, 0);
        check("mid_rst_swap_cnt", swap_cnt, 0);

        // Next job with 0xF offered throughout SORT/OUT and on the final beat
        load_job(4'd3, 4'd3, 4'd1, 4'd8, 1'b1);
        wait_out(10);
        unload(9, 2, 0);

        // Loading must restart cleanly at element 0
        load_job(4'd15, 4'd10, 4'd5, 4'd0, 1'b0);
        wait_out(10);
        unload(9, 6, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
